// File: rtl/ordered_dither_if.sv
// Pixel-stream bundle between the renderer and the ordered-dither stage.
// The master drives position, syncs and colour; the slave returns dithered pixels.
interface ordered_dither_if #(
    parameter int CHANNELS = 3,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2
);
    logic [9:0]                   hpos;
    logic [9:0]                   vpos;
    logic                         hsync_n_in;
    logic                         vsync_n_in;
    logic                         de_in;
    logic                         field_hold;
    logic [CHANNELS*IN_BITS-1:0]  rgb_in;
    logic [CHANNELS*OUT_BITS-1:0] rgb_out;
    logic                         hsync_n_out;
    logic                         vsync_n_out;
    logic                         de_out;
    logic [1:0]                   field;

    modport master (
        output hpos, vpos, hsync_n_in, vsync_n_in, de_in, field_hold, rgb_in,
        input  rgb_out, hsync_n_out, vsync_n_out, de_out, field
    );

    modport slave (
        input  hpos, vpos, hsync_n_in, vsync_n_in, de_in, field_hold, rgb_in,
        output rgb_out, hsync_n_out, vsync_n_out, de_out, field
    );
endinterface

// File: rtl/ordered_dither.sv
// Two-stage ordered (4x4 Bayer) dither from IN_BITS to OUT_BITS per channel,
// with optional field-rotated thresholds and sync/enable carried alongside.
module ordered_dither #(
    parameter int CHANNELS = 3,
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2,
    parameter int TEMPORAL = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    ordered_dither_if.slave bus
);
    localparam int D = IN_BITS - OUT_BITS;

    logic [1:0]          field;
    logic                vs_prev;
    logic [1:0]          x;
    logic [3:0]          b_raw;
    logic [3:0]          b_shift;

    logic [OUT_BITS-1:0] q1    [CHANNELS];
    logic [D-1:0]        frac1 [CHANNELS];
    logic [D-1:0]        t1;
    logic                hs1;
    logic                vs1;
    logic                de1;

    logic [CHANNELS*OUT_BITS-1:0] rgb_next;
    logic [CHANNELS*OUT_BITS-1:0] rgb_q;
    logic                         hs2;
    logic                         vs2;
    logic                         de2;

    logic unused_pos;
    assign unused_pos = ^{bus.hpos[9:2], bus.vpos[9:2]};

    assign x = bus.hpos[1:0] ^ field;

    always_comb begin
        b_raw = '0;
        case ({bus.vpos[1:0], x})
            4'h0: b_raw = 4'd0;
            4'h1: b_raw = 4'd8;
            4'h2: b_raw = 4'd2;
            4'h3: b_raw = 4'd10;
            4'h4: b_raw = 4'd12;
            4'h5: b_raw = 4'd4;
            4'h6: b_raw = 4'd14;
            4'h7: b_raw = 4'd6;
            4'h8: b_raw = 4'd3;
            4'h9: b_raw = 4'd11;
            4'hA: b_raw = 4'd1;
            4'hB: b_raw = 4'd9;
            4'hC: b_raw = 4'd15;
            4'hD: b_raw = 4'd7;
            4'hE: b_raw = 4'd13;
            default: b_raw = 4'd5;
        endcase
        b_shift = b_raw >> (4 - D);
    end

    // A falling vsync edge seen while held is dropped, not deferred.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev <= 1'b1;
            field   <= '0;
        end else begin
            vs_prev <= bus.vsync_n_in;
            if (TEMPORAL != 0 && vs_prev && !bus.vsync_n_in && !bus.field_hold)
                field <= field + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                q1[c]    <= '0;
                frac1[c] <= '0;
            end
            t1  <= '0;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
            de1 <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                q1[c]    <= bus.rgb_in[c*IN_BITS+D +: OUT_BITS];
                frac1[c] <= bus.rgb_in[c*IN_BITS +: D];
            end
            t1  <= b_shift[D-1:0];
            hs1 <= bus.hsync_n_in;
            vs1 <= bus.vsync_n_in;
            de1 <= bus.de_in;
        end
    end

    always_comb begin
        rgb_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (de1) begin
                if (frac1[c] > t1 && q1[c] != '1)
                    rgb_next[c*OUT_BITS +: OUT_BITS] = q1[c] + 1'b1;
                else
                    rgb_next[c*OUT_BITS +: OUT_BITS] = q1[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hs2   <= 1'b1;
            vs2   <= 1'b1;
            de2   <= 1'b0;
        end else begin
            rgb_q <= rgb_next;
            hs2   <= hs1;
            vs2   <= vs1;
            de2   <= de1;
        end
    end

    assign bus.rgb_out     = rgb_q;
    assign bus.hsync_n_out = hs2;
    assign bus.vsync_n_out = vs2;
    assign bus.de_out      = de2;
    assign bus.field       = field;
endmodule
